// File: rtl/sram_1r1w_array.sv
// Synchronous 1-read/1-write memory with a registered 1-cycle read and a single write port.
// Optional macro SRAM_WRITE_BYPASS_EN selects write-first behaviour on same-address collisions (default read-first).
module sram_1r1w_array #(
    parameter  int SIZE       = 1024,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    // One extra bit so SIZE itself is representable when SIZE is a power of two.
    localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH + 1)'(SIZE);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [DATA_WIDTH-1:0] r_read_data;

    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic                  w_wr_commit;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_rd_in_range = ({1'b0, read_addr}  < LP_SIZE);
    assign w_wr_in_range = ({1'b0, write_addr} < LP_SIZE);
    assign w_wr_commit   = write_en && w_wr_in_range;

    // Writes ignore reset so the loader can fill memory while the system is held in reset.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            r_mem[write_addr] <= write_data;
        end
    end

`ifdef SRAM_WRITE_BYPASS_EN
    logic w_bypass_hit;

    assign w_bypass_hit = w_wr_commit && (read_addr == write_addr);

    always_comb begin
        w_rd_word = '0;
        if (!w_rd_in_range) begin
            w_rd_word = '0;
        end else if (w_bypass_hit) begin
            w_rd_word = write_data;
        end else begin
            w_rd_word = r_mem[read_addr];
        end
    end
`else
    // Read-first: a colliding write becomes visible to reads from the next edge onward.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[read_addr];
        end
    end
`endif

    // Reset clears only the output register and takes priority over a read in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else if (read_en) begin
            r_read_data <= w_rd_word;
        end
    end

    assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_1r1w_array.sv
// Bench for sram_1r1w_array (SIZE=1000): directed vector table plus randomized traffic vs. a reference model.
module tb_sram_1r1w_array;

  localparam int SIZE = 1000;
  localparam int DW   = 32;
  localparam int AW   = 10;

`ifdef SRAM_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;

  always #5 clk = ~clk;

  sram_1r1w_array #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  // ---------------- reference model ----------------
  // Memory as an associative array: absent key == never written (unknown contents).
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_rd;
  bit            m_rd_known;

  function automatic void model_edge(input bit rst, input bit re, input int ra,
                                     input bit we, input int wa, input logic [DW-1:0] wd);
    if (rst) begin
      m_rd       = '0;
      m_rd_known = 1'b1;
    end else if (re) begin
      if (ra >= SIZE) begin
        m_rd       = '0;
        m_rd_known = 1'b1;
      end else if (BYPASS && we && wa == ra) begin
        m_rd       = wd;
        m_rd_known = 1'b1;
      end else if (m_mem.exists(ra)) begin
        m_rd       = m_mem[ra];
        m_rd_known = 1'b1;
      end else begin
        m_rd_known = 1'b0;
      end
    end
    if (we && wa < SIZE) m_mem[wa] = wd;
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] exp);
    n_tests++;
    if (read_data !== exp) begin
      n_fail++;
      $display("FAIL %s: read_data=%h expected=%h (t=%0t)", name, read_data, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Apply one clock edge's worth of inputs; outputs are sampled 1ns after the edge.
  task automatic drive_cycle(input bit rst, input bit re, input logic [AW-1:0] ra,
                             input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    reset      = rst;
    read_en    = re;
    read_addr  = ra;
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    @(posedge clk);
    model_edge(rst, re, int'(ra), we, int'(wa), wd);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string         name;
    bit            rst;
    bit            re;
    logic [AW-1:0] ra;
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input bit rst, input bit re, input int ra,
                              input bit we, input int wa, input logic [DW-1:0] wd,
                              input bit chk, input logic [DW-1:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.re = re; v.ra = AW'(ra);
    v.we = we; v.wa = AW'(wa); v.wd = wd; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; read_en = 1'b0; read_addr = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    m_rd = '0; m_rd_known = 1'b0;

    // name          rst re ra    we wa    wd            chk exp
    add("reset_state", 1, 0, 0,    0, 0,    32'h0,        1, 32'h0);
    add("wr5",         0, 0, 0,    1, 5,    32'hDEADBEEF, 1, 32'h0);
    add("idle",        0, 0, 0,    0, 0,    32'h0,        1, 32'h0);
    add("rd5_lat1",    0, 1, 5,    0, 0,    32'h0,        1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++)
      add("hold",      0, 0, 9,    0, 0,    32'h0,        1, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++)
      add("fill",      0, 0, 0,    1, i,    32'h100 + i,  1, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++)
      add("pipe_rd",   0, 1, i,    0, 0,    32'h0,        1, 32'h100 + i);
    add("rewr5",       0, 0, 0,    1, 5,    32'hDEADBEEF, 1, 32'h107);
    add("wr3_old",     0, 0, 0,    1, 3,    32'h11,       1, 32'h107);
    add("collide3",    0, 1, 3,    1, 3,    32'h22,       1, BYPASS ? 32'h22 : 32'h11);
    add("after_col3",  0, 1, 3,    0, 0,    32'h0,        1, 32'h22);
    add("wr7",         0, 0, 0,    1, 7,    32'hAAAA5555, 1, 32'h22);
    add("rd7",         0, 1, 7,    0, 0,    32'h0,        1, 32'hAAAA5555);
    add("reset_prio",  1, 1, 5,    1, 9,    32'h77,       1, 32'h0);
    add("rd9_postrst", 0, 1, 9,    0, 0,    32'h0,        1, 32'h77);
    add("rd5_kept",    0, 1, 5,    0, 0,    32'h0,        1, 32'hDEADBEEF);
    add("wr20",        0, 0, 0,    1, 20,   32'h5678,     1, 32'hDEADBEEF);
    add("indep",       0, 1, 20,   1, 10,   32'h1234,     1, 32'h5678);
    add("rd10",        0, 1, 10,   0, 0,    32'h0,        1, 32'h1234);
    add("wr999",       0, 0, 0,    1, 999,  32'hCAFE,     1, 32'h1234);
    add("rd999",       0, 1, 999,  0, 0,    32'h0,        1, 32'hCAFE);
    add("wr1000_drop", 0, 0, 0,    1, 1000, 32'hBAD,      1, 32'hCAFE);
    add("rd1000",      0, 1, 1000, 0, 0,    32'h0,        1, 32'h0);
    add("rd999_kept",  0, 1, 999,  0, 0,    32'h0,        1, 32'hCAFE);
    add("rd_low_alias",0, 1, 1000-512, 0, 0, 32'h0,       0, 32'h0);
    add("rd1023",      0, 1, 1023, 0, 0,    32'h0,        1, 32'h0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].re, vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].wd);
      if (vecs[i].chk) check(vecs[i].name, vecs[i].exp);
    end

    // Hand-written sequence: out-of-range write must not alias onto 1000-512 or 1000-1000+0.
    drive_cycle(0, 1, AW'(488), 0, '0, '0);
    exp_q.push_back(m_rd);
    if (m_rd_known) check("no_alias_488", exp_q.pop_front());
    else void'(exp_q.pop_front());
    drive_cycle(0, 1, AW'(0), 1, AW'(1001), 32'hFFFF0000);
    check("oob_wr_no_alias0", 32'h100);

    // Randomized traffic, checked against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit            rst, re, we;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] wd;
      rst = ($urandom_range(0, 29) == 0);
      re  = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 2) != 0);
      ra  = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 31));
      wa  = ($urandom_range(0, 3) == 0) ? ra
          : (($urandom_range(0, 2) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 31)));
      wd  = $urandom;
      drive_cycle(rst, re, ra, we, wa, wd);
      if (m_rd_known) begin
        exp_q.push_back(m_rd);
        check("random", exp_q.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_array.md
Name: sram_1r1w_array

Overview:
- Synchronous single-clock memory: one read port, one write port, used simultaneously.
- Reads are registered with a fixed 1-cycle latency; writes commit on the clock edge.
- Used as backing storage for on-chip RAM behind the AXI slave and its JTAG loader path, and elsewhere as a generic register-file or cache array.

Parameters:
- SIZE, default 1024: number of words; need not be a power of two.
- DATA_WIDTH, default 32: bits per word.
- ADDR_WIDTH (localparam): $clog2(SIZE), minimum 1. Width of both address ports.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  active-high synchronous reset; clears the read output register only.
- read_en  input  1  capture a read this cycle.
- read_addr  input  ADDR_WIDTH  read word address.
- read_data  output  DATA_WIDTH  registered read result.
- write_en  input  1  write this cycle.
- write_addr  input  ADDR_WIDTH  write word address.
- write_data  input  DATA_WIDTH  write data.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Storage: SIZE x DATA_WIDTH array.
  - Contents are never cleared by reset; power-up contents are undefined (X in simulation).
- Write:
  - At a rising edge with write_en=1 and write_addr < SIZE: mem[write_addr] <= write_data.
  - Writes are honoured even while reset=1, so the loader can fill memory during system reset.
  - write_addr >= SIZE: write is dropped, with no aliasing.
- Read:
  - At a rising edge with read_en=1: read_data <= mem[read_addr].
  - The result is visible the cycle after the request, i.e. exactly 1 cycle latency.
  - read_en=0: read_data holds its previous value indefinitely.
  - read_addr >= SIZE: read_data <= 0.
- Reset:
  - At a rising edge with reset=1: read_data <= 0, with priority over any read.
  - A read issued in the reset cycle is lost; nothing is queued.
  - Once reset deasserts, reads behave normally from that edge.
- Simultaneous read and write, different addresses: fully independent; both complete.
- Simultaneous read and write, same address: result is governed by the Optional Feature below.
- Back-to-back reads: one read may be issued per cycle, pipelined. A read issued at edge N returns data at edge N+1 regardless of other traffic.
- No handshake, stalls or error outputs; the block is always ready.
- Implementation: inferable block RAM, i.e. a registered read with a single write port. No asynchronous read path to read_data.

Optional Feature:
- Macro: SRAM_WRITE_BYPASS_EN.
- Defined (write-first): when read_en, write_en and read_addr==write_addr (in range) are all true at the same edge, read_data <= write_data. The array is also updated. Implemented with a comparator and output mux ahead of the read register.
- Undefined (read-first): the same case returns the old mem[read_addr]; the new data becomes visible to reads from the next edge.
- Neither mode affects reset priority or out-of-range rules.

Test Plan:
- Basic latency and hold:
  - Write 0xDEADBEEF to addr 5, then idle a cycle.
  - read_en=1, addr 5 -> read_data==0xDEADBEEF exactly 1 cycle later.
  - read_en=0 for 3 cycles -> value held.
- Pipelined reads:
  - Fill addr 0..7 with values 0x100+i.
  - Assert read_en every cycle for addr 0..7 -> read_data sequence 0x100..0x107, one per cycle, each 1 cycle after its request.
- Same-address read/write:
  - mem[3]=0x11. Same edge: write 0x22 to addr 3 and read addr 3.
  - With SRAM_WRITE_BYPASS_EN -> 0x22; without -> 0x11.
  - Either mode: a following read of addr 3 -> 0x22.
- Reset behaviour:
  - read_data=0xAAAA5555. Assert reset one cycle with read_en=1 on addr 5 -> read_data==0.
  - Also write addr 9=0x77 during reset; after reset, read addr 9 -> 0x77 and addr 5 still 0xDEADBEEF.
- Independent ports: same edge, write addr 10=0x1234 and read addr 20 (preloaded 0x5678) -> read_data==0x5678; next read of addr 10 -> 0x1234.
- Non-power-of-two bounds (SIZE=1000, ADDR_WIDTH=10):
  - Write addr 999=0xCAFE, read it -> 0xCAFE.
  - Write addr 1000=0xBAD; read addr 1000 -> 0; addr 999 still 0xCAFE.
